// File: rtl/store_trace_pkg.sv
// Shared types and helpers for the store trace capture block.
// Optional feature macro: STORE_TRACE_TIMESTAMP_EN (adds a cycle timestamp per entry).
package store_trace_pkg;

    // Saturation value for the dropped-store counter
    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    // One captured store
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
`ifdef STORE_TRACE_TIMESTAMP_EN
        logic [31:0] tstamp;
`endif
    } trace_entry_t;

    // Word-aligned and inside [base, base + 4*words); 33-bit compare so a window
    // ending at the top of the address space does not wrap
    function automatic logic window_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned words);
        logic [32:0] lim;
        lim = {1'b0, base} + (33'(words) << 2);
        return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace entries; push/pop arrive pre-qualified from the
// parent. Storage is not reset, only pointers and occupancy.
module trace_fifo
    import store_trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter type         entry_t = trace_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   wdata,
    output entry_t                   rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; when full with push+pop the write lands in the slot being
    // read out this same edge, which is safe since the read is combinational
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= wdata;
    end

    // Head of queue and status flags
    always_comb begin
        rdata = mem[rd_ptr];
        valid = (count != '0);
        full  = (count == CW'(DEPTH));
    end

endmodule

// File: rtl/store_trace_capture.sv
// Captures processor stores that fall inside an address window into a FIFO,
// tracks dropped stores, and latches a completion code.
// Optional feature macro: STORE_TRACE_TIMESTAMP_EN (out_tstamp port + cycle counter).
module store_trace_capture
    import store_trace_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h00000400,
    parameter int unsigned WINDOW_WORDS = 64,
    parameter logic [31:0] DONE_ADDR    = 32'h000003FC,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic                     done,
    output logic [31:0]              done_code
`ifdef STORE_TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]              out_tstamp
`endif
);

    logic         hit_done;
    logic         cap;
    logic         pop;
    logic         push;
    logic         drop;
    logic         full;
    trace_entry_t wentry;
    trace_entry_t rentry;

`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [31:0]  tstamp;

    // Free-running cycle counter stamped onto each entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tstamp <= '0;
        else        tstamp <= tstamp + 32'd1;
    end
`endif

    // Address decode and push/drop qualification; the completion address is never queued
    always_comb begin
        hit_done = MemWrite && (DataAdr == DONE_ADDR);
        cap      = MemWrite && window_hit(DataAdr, BASE_ADDR, WINDOW_WORDS) && !hit_done;
        pop      = out_valid && out_ready;
        push     = cap && (!full || pop);
        drop     = cap && full && !pop;
        wentry      = '0;
        wentry.addr = DataAdr;
        wentry.data = WriteData;
`ifdef STORE_TRACE_TIMESTAMP_EN
        wentry.tstamp = tstamp;
`endif
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (trace_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (rentry),
        .valid (out_valid),
        .full  (full),
        .count (count)
    );

    // Output entry fields
    always_comb begin
        out_addr = rentry.addr;
        out_data = rentry.data;
`ifdef STORE_TRACE_TIMESTAMP_EN
        out_tstamp = rentry.tstamp;
`endif
    end

    // Sticky overflow, saturating drop counter and first-completion latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            done       <= 1'b0;
            done_code  <= '0;
        end else if (clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            done       <= 1'b0;
            done_code  <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_SAT) drop_count <= drop_count + 16'd1;
            end
            if (hit_done && !done) begin
                done      <= 1'b1;
                done_code <= WriteData;
            end
        end
    end

endmodule

// File: tb/tb_store_trace_capture.sv
// Self-checking bench for store_trace_capture: directed scenarios then random
// traffic, compared every cycle against a queue-based reference model.
module tb_store_trace_capture;

    localparam int unsigned DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        done;
    logic [31:0] done_code;
`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [31:0] out_tstamp;
`endif

    store_trace_capture #(
        .BASE_ADDR    (32'h00000400),
        .WINDOW_WORDS (64),
        .DONE_ADDR    (32'h000003FC),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .clr        (clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .done       (done),
        .done_code  (done_code)
`ifdef STORE_TRACE_TIMESTAMP_EN
        ,
        .out_tstamp (out_tstamp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_ovf;
    logic [15:0] m_drops;
    logic        m_done;
    logic [31:0] m_code;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 16'd0;
        m_done  = 1'b0;
        m_code  = 32'd0;
    endtask

    // Effect of the coming clock edge given the inputs now applied
    task automatic model_edge();
        bit in_win;
        bit do_pop;
        int unsigned sz;
        ent_t e;
        if (clr) begin
            model_clear();
            return;
        end
        in_win = MemWrite && (DataAdr % 4 == 0) && (DataAdr >= 32'h400) &&
                 (DataAdr < 32'h400 + 4 * 64) && (DataAdr != 32'h3FC);
        sz     = q.size();
        do_pop = (sz > 0) && out_ready;
        if (do_pop) void'(q.pop_front());
        if (in_win) begin
            if (sz == DEPTH && !do_pop) begin
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end else begin
                e.a = DataAdr;
                e.d = WriteData;
                q.push_back(e);
            end
        end
        if (MemWrite && DataAdr == 32'h3FC && !m_done) begin
            m_done = 1'b1;
            m_code = WriteData;
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".valid"},    32'(out_valid),  32'(q.size() != 0));
        check({ctx, ".count"},    32'(count),      32'(q.size()));
        check({ctx, ".overflow"}, 32'(overflow),   32'(m_ovf));
        check({ctx, ".drops"},    32'(drop_count), 32'(m_drops));
        check({ctx, ".done"},     32'(done),       32'(m_done));
        check({ctx, ".code"},     done_code,       m_code);
        if (q.size() != 0) begin
            check({ctx, ".addr"}, out_addr, q[0].a);
            check({ctx, ".data"}, out_data, q[0].d);
        end
    endtask

    // One clock: apply inputs, advance the model, check just after the edge
    task automatic cyc(input string ctx, input logic mw, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic c);
        MemWrite  = mw;
        DataAdr   = a;
        WriteData = d;
        out_ready = rdy;
        clr       = c;
        model_edge();
        @(posedge clk);
        #1;
        compare_all(ctx);
    endtask

    initial begin
        logic [31:0] a;
        logic        rdy;
        logic        c;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        out_ready = 1'b0;
        clr       = 1'b0;
        model_clear();
        #3;
        compare_all("reset");
        #10;
        reset = 1'b1;

        // single capture, latency 1
        cyc("first", 1'b1, 32'h400, 32'hDEADBEEF, 1'b0, 1'b0);
        cyc("hold",  1'b0, 32'h0,   32'h0,        1'b0, 1'b0);
        cyc("pop1",  1'b0, 32'h0,   32'h0,        1'b1, 1'b0);
        cyc("idle_pop", 1'b0, 32'h0, 32'h0,       1'b1, 1'b0);

        // outside / misaligned / window edges
        cyc("below", 1'b1, 32'h3F0, 32'h11111111, 1'b0, 1'b0);
        cyc("above", 1'b1, 32'h500, 32'h22222222, 1'b0, 1'b0);
        cyc("misal", 1'b1, 32'h402, 32'h33333333, 1'b0, 1'b0);
        cyc("last",  1'b1, 32'h4FC, 32'h44444444, 1'b0, 1'b0);
        cyc("drain", 1'b0, 32'h0,   32'h0,        1'b1, 1'b0);

        // overflow: 17 stores with no consumer
        for (int i = 0; i < 17; i++)
            cyc("fill", 1'b1, 32'h400 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        // full with simultaneous push and pop
        cyc("fullpp", 1'b1, 32'h480, 32'hCAFEF00D, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++)
            cyc("drain16", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc("clr", 1'b1, 32'h404, 32'h55555555, 1'b0, 1'b1);

        // completion store: first code wins, never queued
        cyc("done1", 1'b1, 32'h3FC, 32'h00000001, 1'b0, 1'b0);
        cyc("done2", 1'b1, 32'h3FC, 32'h00000002, 1'b0, 1'b0);

        // asynchronous reset with pending entries
        for (int i = 0; i < 5; i++)
            cyc("pend", 1'b1, 32'h440 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        MemWrite = 1'b0;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        compare_all("async_rst");
        @(posedge clk);
        #3;
        reset = 1'b1;
        compare_all("rst_rel");
        cyc("post_rst", 1'b1, 32'h408, 32'h0BADF00D, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: a = 32'h400 + 32'(4 * $urandom_range(0, 63));
                4:          a = 32'h3FC;
                5:          a = 32'h400 + 32'($urandom_range(0, 255));
                6:          a = 32'h500 + 32'(4 * $urandom_range(0, 3));
                default:    a = $urandom;
            endcase
            rdy = ($urandom_range(0, 2) == 0);
            c   = ($urandom_range(0, 99) == 0);
            cyc("rand", 1'($urandom_range(0, 1)), a, $urandom, rdy, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_trace_capture.md
STORE_TRACE_CAPTURE -- requirements
Module: store_trace_capture

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h00000400, meaning the first byte address of the captured store window.
REQ-002 The block SHALL have parameter WINDOW_WORDS, default 64, meaning the window size in 32-bit words.
REQ-003 The block SHALL have parameter DONE_ADDR, default 32'h000003FC, meaning the store address that signals program completion.
REQ-004 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, at least 2).
REQ-005 The port list SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  processor store strobe.
- DataAdr  in  32  store byte address.
- WriteData  in  32  store data.
- clr  in  1  synchronous flush of FIFO and status.
- out_valid  out  1  entry available.
- out_ready  in  1  consumer accepts entry.
- out_addr  out  32  entry address.
- out_data  out  32  entry data.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: an entry was dropped.
- drop_count  out  16  number of dropped stores, saturating.
- done  out  1  sticky flag: completion store seen.
- done_code  out  32  WriteData of the first completion store.

Function
REQ-006 A store SHALL be captured when MemWrite=1, DataAdr[1:0]=0, and BASE_ADDR <= DataAdr < BASE_ADDR+4*WINDOW_WORDS; all other stores SHALL be ignored.
REQ-007 A captured store SHALL be pushed at the rising clk edge, and out_valid SHALL rise on the following cycle (latency 1); there is no bypass path.
REQ-008 An entry SHALL pop on any edge with out_valid=1 and out_ready=1; out_addr/out_data SHALL hold steady while out_valid=1 and out_ready=0.
REQ-009 Order SHALL be first-in first-out; count SHALL equal pushes minus pops.
REQ-010 Full with push and no pop: the store SHALL be dropped, overflow SHALL be set, and drop_count SHALL increment, saturating at 16'hFFFF.
REQ-011 Full with simultaneous push and pop: both SHALL occur with no drop, and count SHALL stay DEPTH.
REQ-012 Empty with out_ready=1 and no push: nothing SHALL happen; out_data is don't-care while out_valid=0.
REQ-013 A store to DONE_ADDR while done=0 SHALL set done and latch done_code=WriteData; later DONE_ADDR stores SHALL be ignored. DONE_ADDR is never pushed, even if it falls inside the window.
REQ-014 clr=1 SHALL empty the FIFO and zero count, overflow, drop_count, done, and done_code at the edge; a simultaneous store SHALL be discarded. clr has priority over all other events.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-016 reset=0 SHALL asynchronously force out_valid=0, count=0, overflow=0, drop_count=0, done=0, done_code=0, and the pointers to 0; FIFO storage is not reset.
REQ-017 Reset asserted mid-operation SHALL discard all pending entries; the first push after release SHALL appear at out_valid one cycle later.

Configuration
REQ-018 With STORE_TRACE_TIMESTAMP_EN defined, a 32-bit free-running cycle counter (reset 0, wraps) SHALL be stored with each entry and presented on an extra output out_tstamp[31:0], valid alongside out_data. Without the macro, neither the port nor the counter SHALL exist.

Structure
REQ-019 Package store_trace_pkg SHALL hold the entry struct typedef (addr, data, optional tstamp), the DROP_SAT constant (16'hFFFF), and a function that computes the window-hit test.
REQ-020 The FIFO SHALL be a sub-module, trace_fifo, parameterised by DEPTH and entry type; store_trace_capture holds the address decode, done logic, and counters.

Verification
REQ-021 The bench SHALL cover each of the following scenarios:
- Store 0xDEADBEEF to 0x400 with out_ready=0 -> out_valid=1 next cycle, out_addr=0x400, out_data=0xDEADBEEF, count=1.
- Stores to 0x3F0, 0x500, and 0x402 -> none captured, count=0.
- 17 in-window stores with out_ready=0 -> count=16, overflow=1, drop_count=1, and the first entry is still at the output.
- FIFO full, push and pop in the same cycle -> count=16, drop_count unchanged, order preserved.
- Store 0x00000001 then 0x00000002 to 0x3FC -> done=1, done_code=0x00000001, no FIFO entry.
- 5 pending entries, reset pulsed low mid-cycle -> outputs zero immediately; a new store appears one cycle after release.
